// File: rtl/wb_cmd_master.sv
// Wishbone classic-cycle initiator: buffered commands in, one response out
// per command, with a per-transaction acknowledge timeout.
module wb_cmd_master #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [3:0]  cmd_sel,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0] T_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t        state;
    state_t        state_next;
    logic [68:0]   mem [FIFO_DEPTH];
    logic [68:0]   head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [15:0]   tcnt;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          ack;
    logic          tmo;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign cmd_ready = !full && !reset;
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem[rd_ptr];
    assign busy      = (state != IDLE) || !empty;

    // An ack outside a cycle (slave holding it late) must not count.
    assign ack = wbm_ack_i && wbm_cyc_o;
    assign tmo = (tcnt == T_LAST);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = BUS;
                end
            end
            BUS: begin
                if (ack || tmo) state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_we, cmd_sel, cmd_adr, cmd_dat};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            tcnt      <= '0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= head[68];
                        wbm_sel_o <= head[67:64];
                        wbm_adr_o <= head[63:32];
                        wbm_dat_o <= head[68] ? head[31:0] : '0;
                        tcnt      <= '0;
                    end
                end
                BUS: begin
                    tcnt <= tcnt + 1'b1;
                    if (ack || tmo) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= !ack;
                        rsp_dat   <= (ack && !wbm_we_o) ? wbm_dat_i : '0;
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
